// File: rtl/mouse_packet_bus_interface.sv
// rtl/mouse_packet_bus_interface.sv - PS/2 mouse packet assembler with bus-mapped cursor registers
//
// Assembles 3-byte PS/2 mouse packets into a clamped absolute cursor position
// and a button/status register. These are readable and writable on an 8-bit
// shared bus, and an interrupt is raised for every accepted packet.
//
// Ports:
//   CLK                  in     system clock, rising edge
//   RESET                in     synchronous active-high reset
//   BUS_DATA             inout  8-bit shared data bus (high-Z when not driving)
//   BUS_ADDR             in     bus address (status at BASE, X at BASE+1, Y at BASE+2)
//   BUS_WE               in     bus write strobe
//   BYTE_IN              in     received PS/2 byte
//   BYTE_READY           in     one-cycle strobe qualifying BYTE_IN
//   BUS_INTERRUPT_RAISE  out    level interrupt request
//   BUS_INTERRUPT_ACK    in     interrupt acknowledge pulse
module mouse_packet_bus_interface #(
    parameter logic [7:0] BASE_ADDR      = 8'hA0,
    parameter int         MAX_X          = 159,
    parameter int         MAX_Y          = 119,
    parameter int         INIT_X         = 80,
    parameter int         INIT_Y         = 60,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_READY,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam logic [1:0] WAIT_B0 = 2'd0;
    localparam logic [1:0] WAIT_B1 = 2'd1;
    localparam logic [1:0] WAIT_B2 = 2'd2;
    localparam logic [1:0] UPDATE  = 2'd3;

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0]     GAP_LIMIT = GW'(TIMEOUT_CYCLES);
    localparam logic signed [9:0] LIM_X     = 10'(MAX_X);
    localparam logic signed [9:0] LIM_Y     = 10'(MAX_Y);

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gap_q;
    logic          timed_out;

    // Packet fields held from byte 0 (bit3 is only the sync marker, not kept)
    logic [2:0] btn_q;
    logic       xs_q, ys_q, xo_q, yo_q;
    logic [7:0] dx_q, dy_q;

    logic [7:0] x_q, y_q, status_q;
    logic [7:0] rd_data_q;
    logic       drive_q;

    logic signed [9:0] dx_s, dy_s, x_sum, y_sum;
    logic [7:0]        x_new, y_new;
    logic              x_clamp, y_clamp;
    logic              bus_sel;

    assign timed_out = (gap_q == GAP_LIMIT);
    assign bus_sel   = (BUS_ADDR >= BASE_ADDR) && (BUS_ADDR <= BASE_ADDR + 8'd2);
    assign BUS_DATA  = drive_q ? rd_data_q : 8'hzz;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_B0: if (BYTE_READY && BYTE_IN[3]) state_d = WAIT_B1;
            WAIT_B1: if (BYTE_READY) state_d = WAIT_B2;
                     else if (timed_out) state_d = WAIT_B0;
            WAIT_B2: if (BYTE_READY) state_d = UPDATE;
                     else if (timed_out) state_d = WAIT_B0;
            default: state_d = WAIT_B0;   // UPDATE: any byte arriving now is dropped
        endcase
    end

    // 9-bit deltas sign-extended to 10 bits; overflowed axes contribute nothing.
    // Screen Y grows downward, PS/2 Y grows upward, hence the subtraction.
    always_comb begin
        dx_s    = xo_q ? 10'sd0 : $signed({xs_q, xs_q, dx_q});
        dy_s    = yo_q ? 10'sd0 : $signed({ys_q, ys_q, dy_q});
        x_sum   = $signed({2'b00, x_q}) + dx_s;
        y_sum   = $signed({2'b00, y_q}) - dy_s;
        x_new   = x_sum[7:0];
        y_new   = y_sum[7:0];
        x_clamp = 1'b0;
        y_clamp = 1'b0;
        if (x_sum < 0) begin
            x_new = 8'd0;  x_clamp = 1'b1;
        end else if (x_sum > LIM_X) begin
            x_new = 8'(MAX_X);  x_clamp = 1'b1;
        end
        if (y_sum < 0) begin
            y_new = 8'd0;  y_clamp = 1'b1;
        end else if (y_sum > LIM_Y) begin
            y_new = 8'(MAX_Y);  y_clamp = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q             <= WAIT_B0;
            gap_q               <= '0;
            btn_q               <= '0;
            {xs_q, ys_q, xo_q, yo_q} <= '0;
            dx_q                <= '0;
            dy_q                <= '0;
            x_q                 <= 8'(INIT_X);
            y_q                 <= 8'(INIT_Y);
            status_q            <= '0;
            rd_data_q           <= '0;
            drive_q             <= 1'b0;
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            state_q <= state_d;

            if (BYTE_READY)          gap_q <= '0;
            else if (!timed_out)     gap_q <= gap_q + 1'b1;

            if (state_q == WAIT_B0 && BYTE_READY && BYTE_IN[3]) begin
                btn_q <= BYTE_IN[2:0];
                xs_q  <= BYTE_IN[4];
                ys_q  <= BYTE_IN[5];
                xo_q  <= BYTE_IN[6];
                yo_q  <= BYTE_IN[7];
            end
            if (state_q == WAIT_B1 && BYTE_READY) dx_q <= BYTE_IN;
            if (state_q == WAIT_B2 && BYTE_READY) dy_q <= BYTE_IN;

            if (state_q == UPDATE) begin
                x_q      <= x_new;
                y_q      <= y_new;
                status_q <= {yo_q, xo_q, 1'b0, y_clamp, x_clamp, btn_q};
            end

            // Bus writes are placed after the update so they take priority
            if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1) x_q <= BUS_DATA;
            if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'd2) y_q <= BUS_DATA;

            // Reads sample the pre-update register values of this cycle
            drive_q <= !BUS_WE && bus_sel;
            if (!BUS_WE && bus_sel) begin
                case (BUS_ADDR - BASE_ADDR)
                    8'd1:    rd_data_q <= x_q;
                    8'd2:    rd_data_q <= y_q;
                    default: rd_data_q <= status_q;
                endcase
            end

            if (state_q == UPDATE)       BUS_INTERRUPT_RAISE <= 1'b1;
            else if (BUS_INTERRUPT_ACK)  BUS_INTERRUPT_RAISE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mouse_packet_bus_interface.sv
// tb/tb_mouse_packet_bus_interface.sv - directed self-checking bench for mouse_packet_bus_interface
module tb_mouse_packet_bus_interface;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] bus_data;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_ready = 1'b0;
    logic       irq;
    logic       ack = 1'b0;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_data = 8'h00;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // An undriven bus floats to 8'hFF so high-Z is observable as a value
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus_data[i]);
    end
    assign bus_data = tb_drive ? tb_data : 8'hzz;

    mouse_packet_bus_interface #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK                 (clk),
        .RESET               (reset),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (bus_addr),
        .BUS_WE              (bus_we),
        .BYTE_IN             (byte_in),
        .BYTE_READY          (byte_ready),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        tick();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        tick();
        d        = bus_data;
        bus_addr = 8'h00;
        tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a;
        tb_data  = d;
        tb_drive = 1'b1;
        bus_we   = 1'b1;
        tick();
        tb_drive = 1'b0;
        bus_we   = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
        tests++; if (bus_data !== 8'hFF) begin fails++; $display("FAIL reset_hiz got=%h exp=ff(pulled)", bus_data); end
        bus_read(8'hA1, d);
        tests++; if (d !== 8'h50) begin fails++; $display("FAIL reset_x got=%h exp=50", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'h3C) begin fails++; $display("FAIL reset_y got=%h exp=3c", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_status got=%h exp=00", d); end
        tests++; if (bus_data !== 8'hFF) begin fails++; $display("FAIL deselect_hiz got=%h exp=ff(pulled)", bus_data); end
        bus_addr = 8'hA3;
        tick();
        tests++; if (bus_data !== 8'hFF) begin fails++; $display("FAIL a3_hiz got=%h exp=ff(pulled)", bus_data); end
        bus_addr = 8'h00;
        tick();
    endtask

    task automatic test_packet();
        logic [7:0] d;
        send_byte(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_early got=%b exp=0", irq); end
        tick();
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_latency got=%b exp=1", irq); end
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd85) begin fails++; $display("FAIL pkt_x got=%0d exp=85", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd57) begin fails++; $display("FAIL pkt_y got=%0d exp=57", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL pkt_status got=%h exp=00", d); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_held got=%b exp=1", irq); end
        pulse_ack();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_ack got=%b exp=0", irq); end
        pulse_ack();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL ack_idle got=%b exp=0", irq); end
    endtask

    task automatic test_clamp();
        logic [7:0] d;
        bus_write(8'hA1, 8'd5);
        send_packet(8'h19, 8'hF6, 8'h00);
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd0) begin fails++; $display("FAIL clamp_x0 got=%0d exp=0", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h09) begin fails++; $display("FAIL clamp_x0_status got=%h exp=09", d); end
        bus_write(8'hA1, 8'd150);
        send_packet(8'h08, 8'h7F, 8'h00);
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd159) begin fails++; $display("FAIL clamp_xmax got=%0d exp=159", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h08) begin fails++; $display("FAIL clamp_xmax_status got=%h exp=08", d); end
        bus_write(8'hA2, 8'd2);
        send_packet(8'h08, 8'h00, 8'h05);
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd0) begin fails++; $display("FAIL clamp_y0 got=%0d exp=0", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h10) begin fails++; $display("FAIL clamp_y0_status got=%h exp=10", d); end
        pulse_ack();
    endtask

    task automatic test_resync_timeout();
        logic [7:0] d;
        bus_write(8'hA1, 8'd80);
        bus_write(8'hA2, 8'd60);
        send_byte(8'h00);
        send_packet(8'h08, 8'h01, 8'h01);
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd81) begin fails++; $display("FAIL resync_x got=%0d exp=81", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd59) begin fails++; $display("FAIL resync_y got=%0d exp=59", d); end
        pulse_ack();
        send_byte(8'h08);
        repeat (TMO + 1) tick();
        send_packet(8'h08, 8'h02, 8'h00);
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd83) begin fails++; $display("FAIL timeout_x got=%0d exp=83", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd59) begin fails++; $display("FAIL timeout_y got=%0d exp=59", d); end
        pulse_ack();
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        send_byte(8'h48);
        send_byte(8'hFF);
        send_byte(8'h04);
        bus_addr = 8'hA2;
        bus_we   = 1'b0;
        tick();
        tests++; if (bus_data !== 8'd59) begin fails++; $display("FAIL read_pre_update got=%0d exp=59", bus_data); end
        tick();
        tests++; if (bus_data !== 8'd55) begin fails++; $display("FAIL ovf_y got=%0d exp=55", bus_data); end
        bus_addr = 8'h00;
        tick();
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd83) begin fails++; $display("FAIL ovf_x got=%0d exp=83", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h40) begin fails++; $display("FAIL ovf_status got=%h exp=40", d); end
        pulse_ack();
    endtask

    task automatic test_collision();
        logic [7:0] d;
        send_byte(8'h08);
        send_byte(8'h03);
        send_byte(8'h00);
        bus_addr = 8'hA1;
        tb_data  = 8'h10;
        tb_drive = 1'b1;
        bus_we   = 1'b1;
        ack      = 1'b1;
        tick();
        tb_drive = 1'b0;
        bus_we   = 1'b0;
        ack      = 1'b0;
        bus_addr = 8'h00;
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL ack_vs_update got=%b exp=1", irq); end
        bus_read(8'hA1, d);
        tests++; if (d !== 8'h10) begin fails++; $display("FAIL write_wins_x got=%h exp=10", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd55) begin fails++; $display("FAIL collision_y got=%0d exp=55", d); end
        bus_read(8'hA0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL collision_status got=%h exp=00", d); end
        pulse_ack();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL collision_ack got=%b exp=0", irq); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] d;
        send_byte(8'h08);
        send_byte(8'h05);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_byte(8'h01);
        send_packet(8'h08, 8'h01, 8'h00);
        bus_read(8'hA1, d);
        tests++; if (d !== 8'd81) begin fails++; $display("FAIL midreset_x got=%0d exp=81", d); end
        bus_read(8'hA2, d);
        tests++; if (d !== 8'd60) begin fails++; $display("FAIL midreset_y got=%0d exp=60", d); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_clamp();
        test_resync_timeout();
        test_overflow();
        test_collision();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
